aes_stream_ctrl: RTL and testbench
==================================

// Module: aes_stream_ctrl
// PURPOSE
// - Streaming front end for the iterative AES-128 core (ports clk, rst, data, key, read_enable, out_data, done).
// - Buffers input blocks in a DEPTH-entry FIFO, applies the block mode (ECB, CBC-encrypt or CTR), sequences
//   the core one block at a time, and returns results on a valid/ready output.
// - Watchdog on core completion; sticky error flag.
// PARAMETERS
// - DEPTH     4   input FIFO entries; power of 2, >=2
// - TIMEOUT   64  max cycles from read_enable to done before abort; >=2
// PORTS
// - clk        in   1    clock, rising edge
// - rst        in   1    reset, asynchronous, active-high
// - cfg_load   in   1    latch cfg_key/cfg_iv/cfg_mode; honoured only when busy=0
// - cfg_key    in   128  AES-128 key; byte 0 at [7:0]
// - cfg_iv     in   128  CBC IV / CTR initial counter block
// - cfg_mode   in   2    0=ECB, 1=CBC-encrypt, 2=CTR, 3=reserved (treated as ECB)
// - in_valid   in   1    input block valid
// - in_ready   out  1    FIFO can accept; registered, equals !full
// - in_data    in   128  plaintext block; byte 0 at [7:0]
// - out_valid  out  1    result valid; held until out_ready
// - out_ready  in   1    downstream accepts result
// - out_data   out  128  result block
// - busy       out  1    FSM not IDLE or FIFO non-empty
// - err        out  1    sticky; set on watchdog timeout; cleared only by rst or cfg_load
// - core_*     -    -    internal AES instance: read_enable, data, key, out_data, done
// BEHAVIOUR
// - Reset: FIFO empty, in_ready=1, out_valid=0, out_data=0, busy=0, err=0. Key/IV/mode regs and chain/counter = 0.
//   Core read_enable=0. FSM=IDLE. Reset mid-block drops all FIFO contents and the in-flight block.
// - Core contract: core samples data/key while read_enable=1; done is a 1-cycle pulse with out_data valid.
//   read_enable stays high from ISSUE until done; data/key stay stable over that window.
// - FIFO:
//   - Push on in_valid&in_ready.
//   - Pop on the IDLE->ISSUE transition.
//   - Push+pop in the same cycle keeps the count unchanged.
//   - Push while full is impossible: in_ready=0 even if a pop occurs that cycle.
//   - Pointers wrap mod DEPTH.
// - cfg_load with busy=0: latch all cfg_* next edge; chain<=cfg_iv, ctr<=cfg_iv, err<=0.
//   cfg_load with busy=1: ignored entirely.
// - Core data selection:
//   - ECB: core data = blk.
//   - CBC: core data = blk ^ chain.
//   - CTR: core data = ctr.
// - FSM:
//   - IDLE: FIFO non-empty -> ISSUE (pop head into blk).
//   - ISSUE: assert read_enable, clear the watchdog -> WAIT.
//   - WAIT: read_enable=1.
//     - On done: res <= mode-dependent result -> EMIT.
//       - ECB: core out_data.
//       - CBC: core out_data; also chain <= core out_data.
//       - CTR: core out_data ^ blk; also ctr <= ctr+1.
//     - Watchdog reaches TIMEOUT with no done: err<=1, block discarded, chain/ctr unchanged, read_enable=0 -> IDLE.
//   - EMIT: out_valid=1, out_data=res.
//     - out_ready=1: out_valid<=0 next edge -> IDLE.
//     - Otherwise hold out_data stable.
// - CTR increment: bytes 12..15 form a 32-bit big-endian counter (byte 15 least significant), wrap mod 2^32;
//   bytes 0..11 unchanged; FFFFFFFF -> 00000000 with no carry out.
// - Ordering: results leave in input order; one block in flight.
// - Latency: push at edge t, FIFO empty, FSM IDLE -> pop at t+1, read_enable high from t+2, out_valid the cycle after done.
// - busy drops the cycle after the final out handshake with the FIFO empty.
// TESTING
// - ECB FIPS-197: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//   -> out 3925841d02dc09fbdc118597196a0b32; err=0.
// - CBC, iv=0, same key/pt:
//   - First out = 3925841d...0b32.
//   - Second block pt=0 -> out = AES(3925841d...0b32); chain updated.
// - CTR, iv=pt above, in_data=0 -> out = 3925841d...0b32.
//   - Next block's counter = iv with bytes 12..15 +1.
//   - iv bytes 12..15=FFFFFFFF wraps to 00000000, bytes 0..11 unchanged.
// - Backpressure/full:
//   - Push DEPTH+2 blocks with out_ready=0 -> in_ready=0 after DEPTH+1 accepted (DEPTH in FIFO + 1 in flight).
//   - out_data held stable while stalled.
//   - Release -> all blocks out in order, none lost.
// - Watchdog: stub core never asserts done -> err=1 exactly TIMEOUT cycles after read_enable rises.
//   - FSM returns to IDLE; the next block proceeds.
//   - cfg_load at busy=0 clears err.
// - Reset/config: assert rst mid-WAIT with 3 blocks queued -> all outputs at reset values asynchronously, FIFO empty.
//   - cfg_load while busy=1 -> key/mode unchanged.

Source files
------------

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: FIFO-buffered ECB / CBC-encrypt / CTR front end around an
// iterative AES-128 core; one block in flight, results returned in input order.

// One state column per round: SubBytes on four bytes, then optional MixColumns.
// Also reused with mix_en=0 as SubWord in the key schedule.
module aes_col (
  input  logic [3:0][7:0] col_in,
  input  logic            mix_en,
  output logic [3:0][7:0] col_out
);
  localparam logic [2047:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] sb;

  // substitute each byte, then mix the column unless this is the final round
  always_comb begin
    sb = '0;
    for (int r = 0; r < 4; r++) sb[r] = sbox(col_in[r]);
    col_out = sb;
    if (mix_en) begin
      col_out[0] = xt(sb[0]) ^ xt(sb[1]) ^ sb[1] ^ sb[2] ^ sb[3];
      col_out[1] = sb[0] ^ xt(sb[1]) ^ xt(sb[2]) ^ sb[2] ^ sb[3];
      col_out[2] = sb[0] ^ sb[1] ^ xt(sb[2]) ^ xt(sb[3]) ^ sb[3];
      col_out[3] = xt(sb[0]) ^ sb[0] ^ sb[1] ^ sb[2] ^ xt(sb[3]);
    end
  end
endmodule

// Iterative AES-128: loads on read_enable, one round per cycle with on-the-fly
// key expansion, 1-cycle done pulse. Dropping read_enable aborts the block.
module aes_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         read_enable,
  input  logic [127:0] data,
  input  logic [127:0] key,
  output logic [127:0] out_data,
  output logic         done
);
  // [column/word][row/byte]: byte i of the block lives at [i/4][i%4]
  logic [3:0][3:0][7:0] st, sh, mc, rk, rk_nx;
  logic [3:0][7:0]      rot, ksub, tmp;
  logic [7:0]           rcon;
  logic [3:0]           rnd;
  logic                 run, fin;

  // ShiftRows and the key-schedule word rotation
  always_comb begin
    sh  = '0;
    rot = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sh[c][r] = st[(c + r) % 4][r];
    for (int b = 0; b < 4; b++) rot[b] = rk[3][(b + 1) % 4];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_col u_col (.col_in(sh[c]), .mix_en(rnd != 4'd10), .col_out(mc[c]));
  end

  aes_col u_ksub (.col_in(rot), .mix_en(1'b0), .col_out(ksub));

  // next round key from the current one
  always_comb begin
    tmp      = ksub;
    tmp[0]   = ksub[0] ^ rcon;
    rk_nx[0] = rk[0] ^ tmp;
    rk_nx[1] = rk[1] ^ rk_nx[0];
    rk_nx[2] = rk[2] ^ rk_nx[1];
    rk_nx[3] = rk[3] ^ rk_nx[2];
  end

  assign out_data = st;

  // load / round / finish sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= '0; rk <= '0; rcon <= '0; rnd <= '0;
      run <= 1'b0; fin <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!read_enable) begin
        run <= 1'b0;
        fin <= 1'b0;
      end else if (!run && !fin) begin
        st   <= data ^ key;
        rk   <= key;
        rcon <= 8'h01;
        rnd  <= 4'd1;
        run  <= 1'b1;
      end else if (run) begin
        st   <= mc ^ rk_nx;
        rk   <= rk_nx;
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        rnd  <= rnd + 4'd1;
        if (rnd == 4'd10) begin
          run  <= 1'b0;
          fin  <= 1'b1;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

module aes_stream_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic [1:0]   cfg_mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         err
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  localparam logic [1:0] MODE_CBC = 2'd1;
  localparam logic [1:0] MODE_CTR = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT} state_t;
  typedef struct packed {
    logic [127:0] key;
    logic [1:0]   mode;
  } cfg_t;

  state_t state, state_nx;
  cfg_t   cfg_q;

  logic [DEPTH-1:0][127:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nx;
  logic          push, pop, timeout;

  logic [127:0] blk, chain, ctr, ctr_inc;
  logic [31:0]  ctr_word;
  logic [WW-1:0] wd;

  logic         core_read_enable, core_done;
  logic [127:0] core_data, core_key, core_out_data;

  assign push      = in_valid && in_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign out_valid = (state == S_EMIT);
  assign busy      = (state != S_IDLE) || (count != '0);

  // FIFO occupancy; push and pop together leave it unchanged
  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + (AW+1)'(1);
    else if (!push && pop) count_nx = count - (AW+1)'(1);
  end

  // FIFO storage; contents are meaningless once the pointers reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and registered ready (full blocks push even if popping)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nx;
      in_ready <= (count_nx != (AW+1)'(DEPTH));
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next state; a done arriving on the last watchdog cycle still wins
  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    case (state)
      S_IDLE:  if (count != '0) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (core_done) state_nx = S_EMIT;
        else if (wd == WD_MAX) begin
          timeout  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_EMIT:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // CTR step: bytes 12..15 as a big-endian 32-bit counter, byte 15 least significant
  always_comb begin
    ctr_word = {ctr[103:96], ctr[111:104], ctr[119:112], ctr[127:120]} + 32'd1;
    ctr_inc  = {ctr_word[7:0], ctr_word[15:8], ctr_word[23:16], ctr_word[31:24], ctr[95:0]};
  end

  // block-mode input selection; stable for the whole WAIT window
  always_comb begin
    case (cfg_q.mode)
      MODE_CBC: core_data = blk ^ chain;
      MODE_CTR: core_data = ctr;
      default:  core_data = blk;
    endcase
  end

  assign core_key = cfg_q.key;

  // config, block capture, watchdog, chaining state and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q            <= '0;
      blk              <= '0;
      chain            <= '0;
      ctr              <= '0;
      wd               <= '0;
      err              <= 1'b0;
      out_data         <= '0;
      core_read_enable <= 1'b0;
    end else begin
      core_read_enable <= (state_nx == S_WAIT);
      if (cfg_load && !busy) begin
        cfg_q <= '{key: cfg_key, mode: cfg_mode};
        chain <= cfg_iv;
        ctr   <= cfg_iv;
        err   <= 1'b0;
      end
      if (pop) blk <= mem[rd_ptr];
      if (state == S_ISSUE)     wd <= '0;
      else if (state == S_WAIT) wd <= wd + WW'(1);
      if (timeout) err <= 1'b1;
      if (state == S_WAIT && core_done) begin
        case (cfg_q.mode)
          MODE_CBC: begin
            out_data <= core_out_data;
            chain    <= core_out_data;
          end
          MODE_CTR: begin
            out_data <= core_out_data ^ blk;
            ctr      <= ctr_inc;
          end
          default: out_data <= core_out_data;
        endcase
      end
    end
  end

  aes_core u_core (
    .clk         (clk),
    .rst         (rst),
    .read_enable (core_read_enable),
    .data        (core_data),
    .key         (core_key),
    .out_data    (core_out_data),
    .done        (core_done)
  );
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: directed FIPS/CBC/CTR/backpressure/reset steps,
// randomized traffic against a byte-array AES model, and a watchdog instance
// whose TIMEOUT is shorter than the core latency.
module tb_aes_stream_ctrl;
  localparam int WTO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         cfg_load, w_cfg_load;
  logic [127:0] cfg_key, cfg_iv;
  logic [1:0]   cfg_mode;
  logic         in_valid, w_in_valid, in_ready, w_in_ready;
  logic [127:0] in_data;
  logic         out_valid, w_out_valid, out_ready, w_out_ready;
  logic [127:0] out_data, w_out_data;
  logic         busy, w_busy, err, w_err;

  aes_stream_ctrl #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_mode(cfg_mode), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .err(err));

  aes_stream_ctrl #(.DEPTH(4), .TIMEOUT(WTO)) wdt (
    .clk(clk), .rst(rst), .cfg_load(w_cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_mode(cfg_mode), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .busy(w_busy), .err(w_err));

  int npass = 0, nfail = 0, ntot = 0;
  int w_outs = 0;
  logic [127:0] got[$], exp_q[$];
  logic [7:0]   sbox_t [256];

  logic [127:0] m_key, m_chain, m_ctr;
  logic [1:0]   m_mode;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // ---- reference model ----
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] k [176];
    logic [7:0] s [16];
    logic [7:0] n [16];
    logic [7:0] t [4];
    logic [7:0] rc, tmp;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[8*i +: 8];
      s[i] = pt[8*i +: 8] ^ key[8*i +: 8];
    end
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = k[i-4+j];
      if (i % 16 == 0) begin
        tmp  = t[0];
        t[0] = sbox_t[t[1]] ^ rc;
        t[1] = sbox_t[t[2]];
        t[2] = sbox_t[t[3]];
        t[3] = sbox_t[tmp];
        rc   = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) k[i+j] = k[i-16+j] ^ t[j];
    end
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) n[i] = sbox_t[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 10) begin
          s[4*c+0] = gm(n[4*c], 8'h02) ^ gm(n[4*c+1], 8'h03) ^ n[4*c+2] ^ n[4*c+3];
          s[4*c+1] = n[4*c] ^ gm(n[4*c+1], 8'h02) ^ gm(n[4*c+2], 8'h03) ^ n[4*c+3];
          s[4*c+2] = n[4*c] ^ n[4*c+1] ^ gm(n[4*c+2], 8'h02) ^ gm(n[4*c+3], 8'h03);
          s[4*c+3] = gm(n[4*c], 8'h03) ^ n[4*c+1] ^ n[4*c+2] ^ gm(n[4*c+3], 8'h02);
        end else begin
          for (int rr = 0; rr < 4; rr++) s[4*c+rr] = n[4*c+rr];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= k[16*rd+i];
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  // counter block + 1: carry ripples from byte 15 down to byte 12 and stops there
  function automatic logic [127:0] ctr_next(input logic [127:0] v);
    logic [127:0] o = v;
    bit carry = 1'b1;
    for (int b = 15; b >= 12; b--) begin
      if (carry) begin
        o[8*b +: 8] = o[8*b +: 8] + 8'd1;
        carry = (o[8*b +: 8] == 8'h00);
      end
    end
    return o;
  endfunction

  // byte-reverse a vector written in FIPS order (first byte leftmost)
  function automatic logic [127:0] bs(input logic [127:0] x);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = x[127-8*i -: 8];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_push(input logic [127:0] d);
    logic [127:0] o;
    case (m_mode)
      2'd1: begin o = aes_enc(m_key, d ^ m_chain); m_chain = o; end
      2'd2: begin o = aes_enc(m_key, m_ctr) ^ d; m_ctr = ctr_next(m_ctr); end
      default: o = aes_enc(m_key, d);
    endcase
    exp_q.push_back(o);
  endtask

  // ---- stimulus helpers ----
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (!rst && out_valid && out_ready) got.push_back(out_data);
  always @(negedge clk) if (!rst && w_out_valid && w_out_ready) w_outs++;

  task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv, input logic [1:0] md);
    int b = 0;
    while (busy && b < 2000) begin cyc(); b++; end
    if (busy) chk("cfg_wait_idle", 128'(busy), 128'd0);
    cfg_key = k; cfg_iv = iv; cfg_mode = md; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    m_key = k; m_mode = md; m_chain = iv; m_ctr = iv;
  endtask

  task automatic push(input logic [127:0] d, input bit rnd_rdy);
    bit acc = 1'b0;
    int b = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && b < 500) begin
      acc = in_ready;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      cyc();
      b++;
    end
    in_valid = 1'b0;
    if (acc) model_push(d);
    else chk("push_accept", 128'(acc), 128'd1);
  endtask

  task automatic drain(input string tag);
    int b = 0;
    while (got.size() < exp_q.size() && b < 5000) begin
      out_ready = ($urandom_range(0, 1) != 0);
      cyc();
      b++;
    end
    out_ready = 1'b1;
    repeat (3) cyc();
    chk({tag, "_count"}, 128'(got.size()), 128'(exp_q.size()));
    while (got.size() > 0 && exp_q.size() > 0) chk(tag, got.pop_front(), exp_q.pop_front());
    got.delete();
    exp_q.delete();
  endtask

  // one result against a directed constant; keeps the model queue in step
  task automatic get_one(input string tag, input logic [127:0] expv);
    int b = 0;
    out_ready = 1'b1;
    while (got.size() == 0 && b < 500) begin cyc(); b++; end
    if (got.size() == 0) chk({tag, "_arrive"}, 128'(got.size()), 128'd1);
    else chk(tag, got.pop_front(), expv);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  localparam logic [127:0] KEY_F = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_F  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_F  = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin : main
    logic [127:0] key, pt, ct, ivw, d1, d2, d3, hold, k2;
    logic [127:0] blks [6];
    int acc, e, idle, n;

    rst = 1'b1; cfg_load = 1'b0; w_cfg_load = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_mode = '0;
    in_valid = 1'b0; w_in_valid = 1'b0; in_data = '0; out_ready = 1'b1; w_out_ready = 1'b1;
    m_key = '0; m_mode = '0; m_chain = '0; m_ctr = '0;
    build_sbox();
    key = bs(KEY_F); pt = bs(PT_F); ct = bs(CT_F);

    repeat (3) cyc();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_w_err", 128'(w_err), 128'd0);
    rst = 1'b0;
    cyc();

    // ECB known-answer
    do_cfg(key, '0, 2'd0);
    push(pt, 1'b0);
    get_one("ecb_fips", ct);
    chk("ecb_err", 128'(err), 128'd0);

    // CBC with zero IV: first block equals ECB, then chaining
    do_cfg(key, '0, 2'd1);
    push(pt, 1'b0);
    get_one("cbc_blk0", ct);
    push('0, 1'b0);
    get_one("cbc_blk1", aes_enc(key, ct));
    push(pt, 1'b0);
    get_one("cbc_blk2", aes_enc(key, pt ^ aes_enc(key, ct)));

    // CTR: iv = pt, zero data gives the ECB ciphertext; then counter +1
    do_cfg(key, pt, 2'd2);
    push('0, 1'b0);
    get_one("ctr_blk0", ct);
    d1 = rnd128();
    push(d1, 1'b0);
    get_one("ctr_blk1", aes_enc(key, {8'h35, pt[119:0]}) ^ d1);

    // CTR wrap of bytes 12..15
    ivw = {32'hffffffff, rnd128() & {32'h0, {96{1'b1}}}} | {32'hffffffff, 96'h0};
    ivw[95:0] = rnd128();
    d1 = rnd128(); d2 = rnd128(); d3 = rnd128();
    do_cfg(key, ivw, 2'd2);
    push(d1, 1'b0);
    get_one("ctr_wrap0", aes_enc(key, ivw) ^ d1);
    push(d2, 1'b0);
    get_one("ctr_wrap1", aes_enc(key, {32'h0, ivw[95:0]}) ^ d2);
    push(d3, 1'b0);
    get_one("ctr_wrap2", aes_enc(key, {8'h01, 24'h0, ivw[95:0]}) ^ d3);

    // backpressure: DEPTH in FIFO + 1 in flight, then ignored cfg_load while busy
    k2 = rnd128();
    do_cfg(k2, rnd128(), 2'd0);
    for (int i = 0; i < 6; i++) blks[i] = rnd128();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (acc < 6);
      in_data  = blks[acc < 6 ? acc : 5];
      if (in_valid && in_ready) begin
        model_push(blks[acc]);
        acc++;
      end
      cyc();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 128'(acc), 128'd5);
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    chk("bp_busy", 128'(busy), 128'd1);
    chk("bp_head", out_data, exp_q[0]);
    hold = out_data;
    cfg_key = ~k2; cfg_mode = 2'd2; cfg_iv = rnd128(); cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    repeat (5) cyc();
    chk("bp_hold", out_data, hold);
    out_ready = 1'b1;
    push(blks[5], 1'b0);
    drain("bp_order");
    chk("bp_busy_low", 128'(busy), 128'd0);

    // randomized traffic, all modes including the reserved one
    for (int r = 0; r < 6; r++) begin
      do_cfg(rnd128(), rnd128(), 2'($urandom_range(0, 3)));
      n = $urandom_range(3, 8);
      for (int i = 0; i < n; i++) push(rnd128(), 1'b1);
      drain("rand");
    end

    // asynchronous reset mid-WAIT with blocks queued
    do_cfg(rnd128(), rnd128(), 2'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(rnd128(), 1'b0);
    cyc();
    chk("pre_rst_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_out_data", out_data, 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_err", 128'(err), 128'd0);
    cyc();
    rst = 1'b0;
    got.delete(); exp_q.delete();
    m_key = '0; m_mode = '0; m_chain = '0; m_ctr = '0;
    repeat (30) cyc();
    chk("arst_no_out", 128'(got.size()), 128'd0);
    chk("arst_busy_idle", 128'(busy), 128'd0);
    push(rnd128(), 1'b0);
    drain("arst_zero_cfg");

    // watchdog: core latency exceeds WTO, so every block times out
    w_cfg_load = 1'b1;
    cyc();
    w_cfg_load = 1'b0;
    chk("wd_err_init", 128'(w_err), 128'd0);
    in_data = rnd128();
    w_in_valid = 1'b1;
    cyc();                       // first block accepted at this edge (k=0)
    cyc();                       // second block accepted (k=1)
    w_in_valid = 1'b0;
    e = -1; idle = -1;
    for (int k = 2; k < 24; k++) begin
      cyc();
      if (w_err && e < 0) e = k;
      if (!w_busy && idle < 0) idle = k;
    end
    chk("wd_err_time", 128'(e), 128'(2 + WTO));
    chk("wd_idle_time", 128'(idle), 128'(2 * (2 + WTO)));
    chk("wd_err_sticky", 128'(w_err), 128'd1);
    chk("wd_no_out", 128'(w_outs), 128'd0);
    w_cfg_load = 1'b1;
    cyc();
    w_cfg_load = 1'b0;
    chk("wd_err_clear", 128'(w_err), 128'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
